rtc_ts_capture: RTL and testbench
=================================

# rtc_ts_capture

Timestamp capture stage directly downstream of the RTC. On each packet event strobe (SFD seen on TX or RX), it samples both the free-running RTC fields and the syntonised fields. It optionally applies a per-direction ingress/egress latency correction and queues the tagged result in a FIFO. The gPTP engine reads this FIFO to compute link delay and offset.

## Interface
- FIFO_DEPTH, 8, entries in output FIFO (power of 2, ≥2)
- TAG_W, 16, width of event tag (e.g. sequenceId / message type)
- TX_LAT_NS, 0, egress correction in ns, added to TX stamps (0..999_999_999)
- RX_LAT_NS, 0, ingress correction in ns, subtracted from RX stamps (0..999_999_999)

Ports:
- rtc_clk  in  1  single clock, same as RTC
- rtc_reset  in  1  reset, asynchronous, active-low
- rtc_nanosec_field / rtc_sec_field / rtc_epoch_field  in  32/32/16  free-running RTC time
- syntonised_nanosec_field / syntonised_sec_field / syntonised_epoch_field  in  32/32/16  syntonised time
- ts_event_valid  in  1  one-cycle event strobe
- ts_event_dir  in  1  1 = TX, 0 = RX
- ts_event_tag  in  TAG_W  tag stored with the stamp
- ts_out_valid  out  1  FIFO head valid
- ts_out_ready  in  1  consumer accepts head
- ts_out_dir, ts_out_tag  out  1, TAG_W  head metadata
- ts_out_rtc_nanosec / _sec / _epoch  out  32/32/16  corrected RTC stamp
- ts_out_syn_nanosec / _sec / _epoch  out  32/32/16  corrected syntonised stamp
- ts_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- ts_overflow  out  1  sticky, event dropped
- ts_overflow_clr  in  1  clears ts_overflow

## Operation
- S1 (capture): on ts_event_valid = 1, register all six time fields plus dir and tag. The fields are taken as presented in that same cycle.
- S2 (correct), per time source:
  - TX: ns = ns + TX_LAT_NS. If ns ≥ 1_000_000_000, subtract 1e9 and carry into sec.
  - RX: ns = ns − RX_LAT_NS. If negative, add 1e9 and borrow from sec.
  - A sec carry from 0xFFFF_FFFF wraps sec to 0 and increments epoch. A sec borrow from 0 wraps sec to 0xFFFF_FFFF and decrements epoch. Epoch wraps modulo 2^16.
  - Arithmetic uses a 33-bit signed intermediate; one add/subtract normalisation is sufficient.
- S3 (enqueue): write the S2 result into the FIFO.
- The pipeline accepts one event per cycle, back-to-back, with no stall. Events are never back-pressured.
- Read handshake: an entry pops when ts_out_valid & ts_out_ready. Head outputs are stable while valid and not ready.
- FIFO full and write without a same-cycle pop: drop the new entry and set ts_overflow. Full with a simultaneous pop: both write and pop succeed.
- ts_overflow_clr and a new overflow in the same cycle: set wins.

## Timing
- Event sampled at edge N. S1 is valid after N, S2 after N+1, and the FIFO write occurs at N+2. ts_out_valid is high from N+2 onward when the FIFO was empty.
- Latency is 3 edges regardless of configuration.
- ts_count updates on the write/pop edge.
- Reset asserted (at any time, including mid-pipeline) drives the following, immediately and asynchronously:
  - pipeline valids 0 and FIFO pointers 0
  - ts_out_valid 0, ts_count 0, ts_overflow 0
  - all data outputs 0
  - in-flight events are lost
- First event accepted on the first rising edge after reset deasserts.

## Configuration
- RTC_TS_LATENCY_COMP_EN defined: S2 applies TX_LAT_NS / RX_LAT_NS as described above.
- Not defined: S2 is a plain register stage. Stamps are stored uncorrected, and the parameters are ignored. Latency is unchanged (3 edges).

## Structure
- Shared package rtc_pkg:
  - NS_PER_SEC = 1_000_000_000
  - field widths: NS_W = 32, SEC_W = 32, EPOCH_W = 16
  - timestamp struct typedef {epoch, sec, nanosec}
- One sub-module, rtc_ts_fifo: synchronous FIFO, first-word fall-through. Its ports are wr_en, din, full, rd_en, dout, empty, count, and it uses the same rtc_clk / rtc_reset.
- Correction logic is a function in rtc_pkg, instantiated twice (RTC and syntonised).

## Test plan
- Single TX event, RTC = {0, 5, 100}, TX_LAT_NS = 50, macro on → after 3 edges ts_out_valid = 1, nanosec = 150, sec = 5, dir = 1, tag echoed.
- TX carry: RTC ns = 999_999_990, sec = 0xFFFF_FFFF, epoch = 7, TX_LAT_NS = 20 → ns = 10, sec = 0, epoch = 8.
- RX borrow: ns = 5, sec = 0, epoch = 3, RX_LAT_NS = 10 → ns = 999_999_995, sec = 0xFFFF_FFFF, epoch = 2. With the macro off → ns = 5, sec = 0, epoch = 3.
- Overflow: 10 back-to-back events with FIFO_DEPTH = 8 and ts_out_ready = 0 → ts_count = 8 and ts_overflow = 1. Entries 9–10 are dropped. Drain shows tags 0..7 in order.
- Full with simultaneous pop and write (ready = 1): no overflow, ts_count stays 8. Then ts_overflow_clr pulse → ts_overflow = 0.
- Reset asserted one edge after an event strobe → ts_out_valid stays 0 after release and ts_count = 0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared RTC field widths, timestamp type and the latency-correction function
// used by the timestamp capture path.
package rtc_pkg;

  localparam int unsigned NS_PER_SEC = 1_000_000_000;
  localparam int unsigned NS_W       = 32;
  localparam int unsigned SEC_W      = 32;
  localparam int unsigned EPOCH_W    = 16;
  localparam int unsigned SECS_W     = EPOCH_W + SEC_W;

  typedef struct packed {
    logic [EPOCH_W-1:0] epoch;
    logic [SEC_W-1:0]   sec;
    logic [NS_W-1:0]    nanosec;
  } rtc_ts_t;

  // {epoch, sec} is treated as one 48-bit seconds count so that sec carry/borrow
  // ripples into epoch and epoch wraps modulo 2^16 for free.
  function automatic rtc_ts_t rtc_ts_correct(input rtc_ts_t ts, input logic is_tx,
                                             input logic [NS_W-1:0] tx_lat,
                                             input logic [NS_W-1:0] rx_lat);
    logic signed [NS_W:0] ns;
    logic [SECS_W-1:0]    secs;
    rtc_ts_t              res;
    secs = {ts.epoch, ts.sec};
    if (is_tx) begin
      ns = $signed({1'b0, ts.nanosec}) + $signed({1'b0, tx_lat});
      if (ns >= $signed({1'b0, NS_PER_SEC})) begin
        ns   = ns - $signed({1'b0, NS_PER_SEC});
        secs = secs + SECS_W'(1);
      end
    end else begin
      ns = $signed({1'b0, ts.nanosec}) - $signed({1'b0, rx_lat});
      if (ns[NS_W]) begin
        ns   = ns + $signed({1'b0, NS_PER_SEC});
        secs = secs - SECS_W'(1);
      end
    end
    res.epoch   = secs[SECS_W-1:SEC_W];
    res.sec     = secs[SEC_W-1:0];
    res.nanosec = ns[NS_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/rtc_ts_fifo.sv
// Synchronous first-word-fall-through FIFO; dout reads 0 while empty.
module rtc_ts_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       rtc_clk,
  input  logic                       rtc_reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = empty ? '0 : mem[rd_ptr_q];

  // A write into a full FIFO is still accepted when the head pops in the same cycle.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_comb begin
    count_d = count_q;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge rtc_clk) begin
    if (do_wr) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge rtc_clk or negedge rtc_reset) begin
    if (!rtc_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rtc_ts_capture.sv
// Captures RTC and syntonised time on packet events, optionally corrects for
// TX/RX latency (macro RTC_TS_LATENCY_COMP_EN) and queues the result.
module rtc_ts_capture
  import rtc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TAG_W      = 16,
  parameter int unsigned TX_LAT_NS  = 0,
  parameter int unsigned RX_LAT_NS  = 0
) (
  input  logic                          rtc_clk,
  input  logic                          rtc_reset,
  input  logic [NS_W-1:0]               rtc_nanosec_field,
  input  logic [SEC_W-1:0]              rtc_sec_field,
  input  logic [EPOCH_W-1:0]            rtc_epoch_field,
  input  logic [NS_W-1:0]               syntonised_nanosec_field,
  input  logic [SEC_W-1:0]              syntonised_sec_field,
  input  logic [EPOCH_W-1:0]            syntonised_epoch_field,
  input  logic                          ts_event_valid,
  input  logic                          ts_event_dir,
  input  logic [TAG_W-1:0]              ts_event_tag,
  output logic                          ts_out_valid,
  input  logic                          ts_out_ready,
  output logic                          ts_out_dir,
  output logic [TAG_W-1:0]              ts_out_tag,
  output logic [NS_W-1:0]               ts_out_rtc_nanosec,
  output logic [SEC_W-1:0]              ts_out_rtc_sec,
  output logic [EPOCH_W-1:0]            ts_out_rtc_epoch,
  output logic [NS_W-1:0]               ts_out_syn_nanosec,
  output logic [SEC_W-1:0]              ts_out_syn_sec,
  output logic [EPOCH_W-1:0]            ts_out_syn_epoch,
  output logic [$clog2(FIFO_DEPTH):0]   ts_count,
  output logic                          ts_overflow,
  input  logic                          ts_overflow_clr
);

  localparam int unsigned ENTRY_W = 1 + TAG_W + 2 * $bits(rtc_ts_t);

  logic             s1_valid_q, s2_valid_q;
  logic             s1_dir_q, s2_dir_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
  rtc_ts_t          s1_rtc_q, s1_syn_q, s2_rtc_q, s2_syn_q;
  rtc_ts_t          s2_rtc_d, s2_syn_d;
  rtc_ts_t          out_rtc, out_syn;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic             fifo_full, fifo_empty, fifo_rd;
  logic             overflow_q, overflow_set;

`ifdef RTC_TS_LATENCY_COMP_EN
  assign s2_rtc_d = rtc_ts_correct(s1_rtc_q, s1_dir_q, TX_LAT_NS, RX_LAT_NS);
  assign s2_syn_d = rtc_ts_correct(s1_syn_q, s1_dir_q, TX_LAT_NS, RX_LAT_NS);
`else
  logic unused_lat;
  assign unused_lat = ^{TX_LAT_NS, RX_LAT_NS};
  assign s2_rtc_d   = s1_rtc_q;
  assign s2_syn_d   = s1_syn_q;
`endif

  always_ff @(posedge rtc_clk or negedge rtc_reset) begin
    if (!rtc_reset) begin
      s1_valid_q <= 1'b0;
      s1_dir_q   <= 1'b0;
      s1_tag_q   <= '0;
      s1_rtc_q   <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_dir_q   <= 1'b0;
      s2_tag_q   <= '0;
      s2_rtc_q   <= '0;
      s2_syn_q   <= '0;
    end else begin
      s1_valid_q <= ts_event_valid;
      if (ts_event_valid) begin
        s1_dir_q <= ts_event_dir;
        s1_tag_q <= ts_event_tag;
        s1_rtc_q <= '{epoch: rtc_epoch_field, sec: rtc_sec_field, nanosec: rtc_nanosec_field};
        s1_syn_q <= '{epoch: syntonised_epoch_field, sec: syntonised_sec_field,
                      nanosec: syntonised_nanosec_field};
      end
      s2_valid_q <= s1_valid_q;
      s2_dir_q   <= s1_dir_q;
      s2_tag_q   <= s1_tag_q;
      s2_rtc_q   <= s2_rtc_d;
      s2_syn_q   <= s2_syn_d;
    end
  end

  assign fifo_din = {s2_dir_q, s2_tag_q, s2_rtc_q, s2_syn_q};
  assign fifo_rd  = ts_out_valid & ts_out_ready;

  rtc_ts_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .rtc_clk   (rtc_clk),
    .rtc_reset (rtc_reset),
    .wr_en     (s2_valid_q),
    .din       (fifo_din),
    .full      (fifo_full),
    .rd_en     (fifo_rd),
    .dout      (fifo_dout),
    .empty     (fifo_empty),
    .count     (ts_count)
  );

  assign ts_out_valid = ~fifo_empty;
  assign {ts_out_dir, ts_out_tag, out_rtc, out_syn} = fifo_dout;
  assign ts_out_rtc_nanosec = out_rtc.nanosec;
  assign ts_out_rtc_sec     = out_rtc.sec;
  assign ts_out_rtc_epoch   = out_rtc.epoch;
  assign ts_out_syn_nanosec = out_syn.nanosec;
  assign ts_out_syn_sec     = out_syn.sec;
  assign ts_out_syn_epoch   = out_syn.epoch;

  // A new drop takes priority over a clear in the same cycle.
  assign overflow_set = s2_valid_q & fifo_full & ~fifo_rd;
  assign ts_overflow  = overflow_q;

  always_ff @(posedge rtc_clk or negedge rtc_reset) begin
    if (!rtc_reset) begin
      overflow_q <= 1'b0;
    end else if (overflow_set) begin
      overflow_q <= 1'b1;
    end else if (ts_overflow_clr) begin
      overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rtc_ts_capture.sv
// Bench for rtc_ts_capture: directed test-plan steps plus randomized traffic
// against a queue-based reference model.
module tb_rtc_ts_capture;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TX_LAT = 50;
  localparam int unsigned RX_LAT = 10;
`ifdef RTC_TS_LATENCY_COMP_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif

  logic        rtc_clk = 1'b0;
  logic        rtc_reset = 1'b1;
  logic [31:0] r_ns = '0, r_sec = '0, s_ns = '0, s_sec = '0;
  logic [15:0] r_ep = '0, s_ep = '0;
  logic        ev_valid = 1'b0, ev_dir = 1'b0, ready = 1'b0, ov_clr = 1'b0;
  logic [15:0] ev_tag = '0;
  logic        out_valid, out_dir, overflow;
  logic [15:0] out_tag, o_rep, o_sep;
  logic [31:0] o_rns, o_rsec, o_sns, o_ssec;
  logic [3:0]  count;

  always #5 rtc_clk = ~rtc_clk;

  rtc_ts_capture #(
    .FIFO_DEPTH (DEPTH),
    .TAG_W      (16),
    .TX_LAT_NS  (TX_LAT),
    .RX_LAT_NS  (RX_LAT)
  ) dut (
    .rtc_clk                  (rtc_clk),
    .rtc_reset                (rtc_reset),
    .rtc_nanosec_field        (r_ns),
    .rtc_sec_field            (r_sec),
    .rtc_epoch_field          (r_ep),
    .syntonised_nanosec_field (s_ns),
    .syntonised_sec_field     (s_sec),
    .syntonised_epoch_field   (s_ep),
    .ts_event_valid           (ev_valid),
    .ts_event_dir             (ev_dir),
    .ts_event_tag             (ev_tag),
    .ts_out_valid             (out_valid),
    .ts_out_ready             (ready),
    .ts_out_dir               (out_dir),
    .ts_out_tag               (out_tag),
    .ts_out_rtc_nanosec       (o_rns),
    .ts_out_rtc_sec           (o_rsec),
    .ts_out_rtc_epoch         (o_rep),
    .ts_out_syn_nanosec       (o_sns),
    .ts_out_syn_sec           (o_ssec),
    .ts_out_syn_epoch         (o_sep),
    .ts_count                 (count),
    .ts_overflow              (overflow),
    .ts_overflow_clr          (ov_clr)
  );

  typedef struct {
    bit        dir;
    bit [15:0] tag;
    bit [79:0] rtc;
    bit [79:0] syn;
  } entry_t;

  int     checks = 0;
  int     failures = 0;
  entry_t q[$];
  entry_t p1, p2;
  bit     p1v = 0, p2v = 0, m_ov = 0;

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Time as a whole-seconds count plus nanoseconds; returns {epoch, sec, ns}.
  function automatic bit [79:0] model_ts(bit dir, bit [15:0] ep, bit [31:0] sec, bit [31:0] ns);
    longint n = longint'(ns);
    longint s = longint'({ep, sec});
    if (COMP) begin
      n = dir ? n + longint'(TX_LAT) : n - longint'(RX_LAT);
      if (n >= 64'd1_000_000_000) begin
        n -= 1_000_000_000;
        s += 1;
      end else if (n < 0) begin
        n += 1_000_000_000;
        s -= 1;
      end
    end
    s = s & 64'h0000_FFFF_FFFF_FFFF;
    return {s[47:0], n[31:0]};
  endfunction

  task automatic model_step();
    bit pop = (q.size() > 0) && ready;
    int sz = q.size();
    bit over = 0;
    if (pop) void'(q.pop_front());
    if (p2v) begin
      if (sz == DEPTH && !pop) over = 1;
      else q.push_back(p2);
    end
    if (over) m_ov = 1;
    else if (ov_clr) m_ov = 0;
    p2v = p1v;
    p2  = p1;
    p1v = ev_valid;
    if (ev_valid) begin
      p1.dir = ev_dir;
      p1.tag = ev_tag;
      p1.rtc = model_ts(ev_dir, r_ep, r_sec, r_ns);
      p1.syn = model_ts(ev_dir, s_ep, s_sec, s_ns);
    end
  endtask

  task automatic model_reset();
    q.delete();
    p1v = 0;
    p2v = 0;
    m_ov = 0;
  endtask

  task automatic check_all();
    chk("valid", 256'(out_valid), 256'(q.size() > 0));
    chk("count", 256'(count), 256'(q.size()));
    chk("overflow", 256'(overflow), 256'(m_ov));
    if (q.size() > 0)
      chk("head", {out_dir, out_tag, o_rep, o_rsec, o_rns, o_sep, o_ssec, o_sns},
          {q[0].dir, q[0].tag, q[0].rtc, q[0].syn});
  endtask

  task automatic tick();
    @(posedge rtc_clk);
    model_step();
    @(negedge rtc_clk);
    check_all();
  endtask

  task automatic set_ev(input bit v, input bit dir, input bit [15:0] tag,
                        input bit [15:0] rep, input bit [31:0] rsec, input bit [31:0] rns);
    ev_valid = v;
    ev_dir   = dir;
    ev_tag   = tag;
    r_ep     = rep;
    r_sec    = rsec;
    r_ns     = rns;
    s_ep     = 16'($urandom);
    s_sec    = $urandom;
    s_ns     = $urandom_range(999_999_999, 0);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_valid"}, 256'(out_valid), 256'(0));
    chk({name, "_count"}, 256'(count), 256'(0));
    chk({name, "_ovf"}, 256'(overflow), 256'(0));
    chk({name, "_data"}, {out_dir, out_tag, o_rep, o_rsec, o_rns, o_sep, o_ssec, o_sns}, '0);
  endtask

  int drain_exp[8] = '{1, 2, 3, 4, 5, 6, 7, 100};

  initial begin
    #1 rtc_reset = 1'b0;
    @(negedge rtc_clk);
    @(negedge rtc_clk);
    chk_zero_outputs("reset");
    rtc_reset = 1'b1;

    // Single TX event; RTC time {0, 5, 100}.
    set_ev(1, 1, 16'hABCD, 16'd0, 32'd5, 32'd100);
    tick();
    ev_valid = 0;
    tick();
    chk("tx_not_yet", 256'(out_valid), 256'(0));
    tick();
    chk("tx_valid", 256'(out_valid), 256'(1));
    chk("tx_ns", 256'(o_rns), COMP ? 256'(150) : 256'(100));
    chk("tx_sec", 256'(o_rsec), 256'(5));
    chk("tx_dir_tag", {out_dir, out_tag}, {1'b1, 16'hABCD});
    ready = 1;
    tick();
    ready = 0;

    // TX carry across sec wrap into epoch.
    set_ev(1, 1, 16'h0002, 16'd7, 32'hFFFF_FFFF, 32'd999_999_960);
    tick();
    ev_valid = 0;
    tick();
    tick();
    chk("carry", {o_rep, o_rsec, o_rns},
        COMP ? {16'd8, 32'd0, 32'd10} : {16'd7, 32'hFFFF_FFFF, 32'd999_999_960});
    ready = 1;
    tick();
    ready = 0;

    // RX borrow from sec 0 into epoch.
    set_ev(1, 0, 16'h0003, 16'd3, 32'd0, 32'd5);
    tick();
    ev_valid = 0;
    tick();
    tick();
    chk("borrow", {o_rep, o_rsec, o_rns},
        COMP ? {16'd2, 32'hFFFF_FFFF, 32'd999_999_995} : {16'd3, 32'd0, 32'd5});
    ready = 1;
    tick();
    ready = 0;

    // Overflow: ten back-to-back events into an eight-deep FIFO.
    for (int i = 0; i < 10; i++) begin
      set_ev(1, i[0], 16'(i), 16'($urandom), $urandom, $urandom_range(999_999_999, 0));
      tick();
    end
    ev_valid = 0;
    tick();
    tick();
    chk("ovf_count", 256'(count), 256'(8));
    chk("ovf_flag", 256'(overflow), 256'(1));
    ov_clr = 1;
    tick();
    ov_clr = 0;
    chk("ovf_clr", 256'(overflow), 256'(0));

    // Full FIFO: write and pop in the same cycle.
    chk("head_tag0", 256'(out_tag), 256'(0));
    set_ev(1, 1, 16'd100, 16'd1, 32'd1, 32'd1);
    tick();
    ev_valid = 0;
    tick();
    ready = 1;
    tick();
    ready = 0;
    chk("full_pop_count", 256'(count), 256'(8));
    chk("full_pop_ovf", 256'(overflow), 256'(0));
    ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_tag", 256'(out_tag), 256'(drain_exp[i]));
      tick();
    end
    ready = 0;
    chk("drained", 256'(count), 256'(0));

    // Randomized traffic with boundary-heavy time values.
    for (int i = 0; i < 400; i++) begin
      int unsigned mode = $urandom_range(3, 0);
      bit [31:0]   ns;
      bit [31:0]   sec;
      case (mode)
        0:       begin ns = $urandom_range(999_999_999, 999_999_900); sec = 32'hFFFF_FFFF; end
        1:       begin ns = $urandom_range(20, 0); sec = 32'd0; end
        default: begin ns = $urandom_range(999_999_999, 0); sec = $urandom; end
      endcase
      set_ev($urandom_range(2, 0) != 0, 1'($urandom), 16'($urandom), 16'($urandom), sec, ns);
      s_sec  = sec;
      ready  = $urandom_range(2, 0) == 0;
      ov_clr = $urandom_range(15, 0) == 0;
      tick();
    end
    ev_valid = 0;
    ov_clr = 0;

    // Reset one edge after an event strobe, with entries already queued.
    ready = 0;
    set_ev(1, 1, 16'h0055, 16'd1, 32'd2, 32'd3);
    tick();
    ev_valid = 0;
    @(posedge rtc_clk);
    #2 rtc_reset = 1'b0;
    model_reset();
    #1 chk_zero_outputs("async_rst");
    @(negedge rtc_clk);
    rtc_reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_valid", 256'(out_valid), 256'(0));
    chk("post_rst_count", 256'(count), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
